// File: rtl/quadrature_pkg.sv
// quadrature_pkg
//   Shared definitions for the quadrature encoder/decoder pair: the AB state
//   encoding, direction constants and the clockwise successor function, so
//   both stages agree on the rotation sequence.
//   No ports (package).
package quadrature_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } ab_t;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // Clockwise sequence (AB): 00 -> 10 -> 11 -> 01 -> 00
    function automatic ab_t next_cw(input ab_t s);
        case (s)
            S0:      next_cw = S2;
            S2:      next_cw = S3;
            S3:      next_cw = S1;
            default: next_cw = S0;
        endcase
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// quad_input_filter
//   Two-flop synchroniser plus FILTER_LEN glitch filter on the 2-bit AB bus.
//   A synchronised value that differs from the accepted state must be seen
//   unchanged on FILTER_LEN consecutive edges before it is accepted.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   ab_i      in   raw {A,B}, asynchronous to clk
//   q_o       out  currently accepted AB state (the old state during a strobe)
//   accept_o  out  high in the cycle whose closing edge accepts q_new_o
//   q_new_o   out  state being accepted while accept_o is high
module quad_input_filter
    import quadrature_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ab_i,
    output ab_t        q_o,
    output logic       accept_o,
    output ab_t        q_new_o
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LEN = CW'(FILTER_LEN);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [1:0]    sync1_q, sync2_q;
    ab_t           s;
    ab_t           cand_q, cand_d;
    ab_t           q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign s = ab_t'(sync2_q);

    // accept_o is combinational so the decoder registers its effects on the
    // same edge that updates q_q, keeping q and the outputs in lockstep.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        accept_o = 1'b0;
        if (s == q_q) begin
            cnt_d = '0;
        end else begin
            cand_d = s;
            cnt_d  = (s == cand_q && cnt_q != '0) ? cnt_q + ONE : ONE;
            if (cnt_d == LEN) begin
                accept_o = 1'b1;
                q_d      = s;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= S0;
            cnt_q   <= '0;
            q_q     <= S0;
        end else begin
            sync1_q <= ab_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    assign q_o     = q_q;
    assign q_new_o = s;

endmodule

// File: rtl/quadrature_decoder.sv
// quadrature_decoder
//   Decodes a filtered quadrature pair into a signed position count,
//   per-step direction pulses and a sticky illegal-transition flag.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   A, B      in   quadrature phases, asynchronous
//   clr       in   synchronous clear of count (wins over a step)
//   err_clr   in   synchronous clear of err (loses to a new illegal step)
//   count     out  signed position, modulo 2^CNT_WIDTH
//   step_cw   out  one-cycle pulse per clockwise step
//   step_ccw  out  one-cycle pulse per counter-clockwise step
//   dir       out  direction of last valid step (1 = CW)
//   err       out  sticky illegal-transition flag
module quadrature_decoder
    import quadrature_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned FILTER_LEN = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        A,
    input  logic                        B,
    input  logic                        clr,
    input  logic                        err_clr,
    output logic signed [CNT_WIDTH-1:0] count,
    output logic                        step_cw,
    output logic                        step_ccw,
    output logic                        dir,
    output logic                        err
);

    localparam logic signed [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    ab_t  q_old, q_new;
    logic accept;
    logic is_cw, is_ccw, is_ill;

    logic signed [CNT_WIDTH-1:0] count_q, count_d;
    logic step_cw_q, step_cw_d;
    logic step_ccw_q, step_ccw_d;
    logic dir_q, dir_d;
    logic err_q, err_d;

    quad_input_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .ab_i     ({A, B}),
        .q_o      (q_old),
        .accept_o (accept),
        .q_new_o  (q_new)
    );

    always_comb begin
        is_cw      = accept && (q_new == next_cw(q_old));
        is_ccw     = accept && (q_old == next_cw(q_new));
        // the filter never accepts q_new == q_old, so anything left flips both bits
        is_ill     = accept && !is_cw && !is_ccw;
        count_d    = count_q;
        dir_d      = dir_q;
        err_d      = err_q;
        step_cw_d  = is_cw;
        step_ccw_d = is_ccw;
        if (is_cw) begin
            count_d = count_q + ONE;
            dir_d   = DIR_CW;
        end else if (is_ccw) begin
            count_d = count_q - ONE;
            dir_d   = DIR_CCW;
        end
        if (clr) begin
            count_d = '0;
        end
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (is_ill) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            step_cw_q  <= 1'b0;
            step_ccw_q <= 1'b0;
            dir_q      <= DIR_CCW;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            step_cw_q  <= step_cw_d;
            step_ccw_q <= step_ccw_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign count    = count_q;
    assign step_cw  = step_cw_q;
    assign step_ccw = step_ccw_q;
    assign dir      = dir_q;
    assign err      = err_q;

endmodule
